// File: rtl/cram_read_streamer.sv
// Sequences block reads from one CRAM port and re-times the returning data into
// a gap-free valid/data/last stream for the downstream swizzle buffers.
module cram_read_streamer #(
  parameter int DWIDTH      = 40,
  parameter int AWIDTH      = 9,
  parameter int RD_LATENCY  = 1,
  parameter int BLOCK_WORDS = 40,
  parameter int NBLK_WIDTH  = 7
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [AWIDTH-1:0]     start_addr,
  input  logic [NBLK_WIDTH-1:0] num_blocks,
  input  logic                  pause,
  output logic                  busy,
  output logic                  done,
  output logic [AWIDTH-1:0]     ram_addr,
  output logic                  ram_re,
  input  logic [DWIDTH-1:0]     ram_rdata,
  output logic                  data_valid,
  output logic [DWIDTH-1:0]     ram_data_out,
  output logic                  ram_data_last
);

  localparam int TWIDTH = NBLK_WIDTH + 6;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

  state_t                  state_r;
  logic [AWIDTH-1:0]       addr_r;
  logic [TWIDTH-1:0]       total_r;
  logic [TWIDTH-1:0]       count_r;
  logic                    busy_r;
  logic                    done_r;
  logic [RD_LATENCY-1:0]   tag_v_r;
  logic [RD_LATENCY-1:0]   tag_l_r;
  logic                    dv_r;
  logic                    last_r;
  logic [DWIDTH-1:0]       data_r;
  logic                    issue_s;
  logic                    issue_last_s;

  // pause must suppress the read in the same cycle, so the read strobe is decoded from state
  assign issue_s      = (state_r == S_ISSUE) && !pause;
  assign issue_last_s = issue_s && (count_r == (total_r - TWIDTH'(1)));

  assign ram_re        = issue_s;
  assign ram_addr      = addr_r;
  assign busy          = busy_r;
  assign done          = done_r;
  assign data_valid    = dv_r;
  assign ram_data_out  = data_r;
  assign ram_data_last = last_r;

  // Command FSM: address/count sequencing and busy/done handshake
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= S_IDLE;
      addr_r  <= {AWIDTH{1'b0}};
      total_r <= {TWIDTH{1'b0}};
      count_r <= {TWIDTH{1'b0}};
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      case (state_r)
        S_IDLE: begin
          done_r <= 1'b0;
          if (start) begin
            if (num_blocks != {NBLK_WIDTH{1'b0}}) begin
              addr_r  <= start_addr;
              total_r <= TWIDTH'(num_blocks) * TWIDTH'(BLOCK_WORDS);
              count_r <= {TWIDTH{1'b0}};
              busy_r  <= 1'b1;
              state_r <= S_ISSUE;
            end else begin
              done_r  <= 1'b1;
              state_r <= S_DONE;
            end
          end else begin
            state_r <= S_IDLE;
          end
        end
        S_ISSUE: begin
          if (issue_s) begin
            addr_r  <= addr_r + AWIDTH'(1);
            count_r <= count_r + TWIDTH'(1);
            if (issue_last_s) begin
              state_r <= S_DRAIN;
            end else begin
              state_r <= S_ISSUE;
            end
          end else begin
            state_r <= S_ISSUE;
          end
        end
        S_DRAIN: begin
          // the tagged last word leaving the output register means nothing is left in flight
          if (dv_r && last_r) begin
            busy_r  <= 1'b0;
            done_r  <= 1'b1;
            state_r <= S_DONE;
          end else begin
            state_r <= S_DRAIN;
          end
        end
        S_DONE: begin
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
          state_r <= S_IDLE;
        end
        default: begin
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
          state_r <= S_IDLE;
        end
      endcase
    end
  end

  // Tag pipe: {valid, last} travels alongside each read for RD_LATENCY cycles
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tag_v_r <= {RD_LATENCY{1'b0}};
      tag_l_r <= {RD_LATENCY{1'b0}};
    end else begin
      tag_v_r[0] <= issue_s;
      tag_l_r[0] <= issue_last_s;
      for (int i = 1; i < RD_LATENCY; i++) begin
        tag_v_r[i] <= tag_v_r[i-1];
        tag_l_r[i] <= tag_l_r[i-1];
      end
    end
  end

  // Output register: captures read data at pipe exit, holds it between valid words
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dv_r   <= 1'b0;
      last_r <= 1'b0;
      data_r <= {DWIDTH{1'b0}};
    end else begin
      dv_r   <= tag_v_r[RD_LATENCY-1];
      last_r <= tag_l_r[RD_LATENCY-1];
      if (tag_v_r[RD_LATENCY-1]) begin
        data_r <= ram_rdata;
      end else begin
        data_r <= data_r;
      end
    end
  end

endmodule

// File: tb/tb_cram_read_streamer.sv
// Directed bench for cram_read_streamer: one instance at RD_LATENCY=1, one at 3,
// each fed by a behavioural CRAM whose contents are a fixed function of address.
module tb_cram_read_streamer;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        sel_r;
  logic [8:0]  start_addr;
  logic [6:0]  num_blocks;
  logic        pause;

  logic        busy1, done1, re1, dv1, last1;
  logic [8:0]  addr1;
  logic [39:0] dout1, rdata1;
  logic        busy3, done3, re3, dv3, last3;
  logic [8:0]  addr3;
  logic [39:0] dout3, rdata3, p3a, p3b;

  logic        obs_busy, obs_done, obs_re, obs_dv, obs_last;
  logic [8:0]  obs_addr;
  logic [39:0] obs_data;

  int checks = 0;
  int errors = 0;

  int n_re, ord_err, first_re, last_re, n_dv, data_err, first_dv, last_dv;
  int n_last, stray_last, last_cyc, n_done, done_cyc, busy_n, busy_first, busy_last;
  int dv10_cyc, dv11_cyc;

  always #5 clk = ~clk;

  function automatic logic [39:0] mdata(input logic [8:0] a);
    return {a, ~a, 22'h2A5A5};
  endfunction

  cram_read_streamer #(.RD_LATENCY(1)) u1 (
    .clk(clk), .reset(reset), .start(start & ~sel_r), .start_addr(start_addr),
    .num_blocks(num_blocks), .pause(pause & ~sel_r), .busy(busy1), .done(done1),
    .ram_addr(addr1), .ram_re(re1), .ram_rdata(rdata1), .data_valid(dv1),
    .ram_data_out(dout1), .ram_data_last(last1));

  cram_read_streamer #(.RD_LATENCY(3)) u3 (
    .clk(clk), .reset(reset), .start(start & sel_r), .start_addr(start_addr),
    .num_blocks(num_blocks), .pause(pause & sel_r), .busy(busy3), .done(done3),
    .ram_addr(addr3), .ram_re(re3), .ram_rdata(rdata3), .data_valid(dv3),
    .ram_data_out(dout3), .ram_data_last(last3));

  always @(posedge clk) rdata1 <= re1 ? mdata(addr1) : 40'hDEADBEEF00;
  always @(posedge clk) begin
    p3a    <= re3 ? mdata(addr3) : 40'hDEADBEEF00;
    p3b    <= p3a;
    rdata3 <= p3b;
  end

  assign obs_busy = sel_r ? busy3 : busy1;
  assign obs_done = sel_r ? done3 : done1;
  assign obs_re   = sel_r ? re3   : re1;
  assign obs_dv   = sel_r ? dv3   : dv1;
  assign obs_last = sel_r ? last3 : last1;
  assign obs_addr = sel_r ? addr3 : addr1;
  assign obs_data = sel_r ? dout3 : dout1;

  // Issues one command and records what the selected instance does, cycle 1 = cycle after the start edge
  task automatic run_cmd(input logic sel, input logic [8:0] a, input logic [6:0] nb,
                         input int pause_at, input int pause_len, input int restart_at);
    int post;
    logic [8:0] ea;
    n_re = 0; ord_err = 0; first_re = -1; last_re = -1; n_dv = 0; data_err = 0;
    first_dv = -1; last_dv = -1; n_last = 0; stray_last = 0; last_cyc = -1;
    n_done = 0; done_cyc = -1; busy_n = 0; busy_first = -1; busy_last = -1;
    dv10_cyc = -1; dv11_cyc = -1; post = -1;
    @(negedge clk);
    sel_r = sel; start = 1'b1; start_addr = a; num_blocks = nb;
    @(posedge clk);
    for (int cyc = 1; cyc <= 200; cyc++) begin
      #1;
      pause = (cyc >= pause_at) && (cyc < pause_at + pause_len);
      start = (cyc == restart_at);
      if (cyc == restart_at) start_addr = a + 9'd100;
      #1;
      if (obs_re) begin
        ea = a + 9'(n_re);
        if (obs_addr !== ea) ord_err++;
        if (first_re < 0) first_re = cyc;
        last_re = cyc;
        n_re++;
      end
      if (obs_dv) begin
        ea = a + 9'(n_dv);
        if (obs_data !== mdata(ea)) data_err++;
        if (first_dv < 0) first_dv = cyc;
        n_dv++;
        if (n_dv == 10) dv10_cyc = cyc;
        if (n_dv == 11) dv11_cyc = cyc;
        last_dv = cyc;
      end
      if (obs_last) begin
        if (!obs_dv) stray_last++;
        n_last++;
        last_cyc = cyc;
      end
      if (obs_busy) begin
        if (busy_first < 0) busy_first = cyc;
        busy_last = cyc;
        busy_n++;
      end
      if (obs_done) begin
        n_done++;
        done_cyc = cyc;
        if (post < 0) post = 0;
      end
      if (post >= 0) post++;
      if (post > 3) break;
      @(posedge clk);
    end
    start = 1'b0; pause = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1; start = 1'b0; sel_r = 1'b0; pause = 1'b0;
    start_addr = 9'd0; num_blocks = 7'd0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({busy1, done1, re1, dv1, last1, addr1, dout1} !== 54'd0 ||
        {busy3, done3, re3, dv3, last3, addr3, dout3} !== 54'd0) begin
      errors++;
      $display("FAIL reset_outputs: u1=%h u3=%h required all zero",
               {busy1, done1, re1, dv1, last1, addr1, dout1},
               {busy3, done3, re3, dv3, last3, addr3, dout3});
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_basic;
    run_cmd(1'b0, 9'd0, 7'd2, 1000, 0, -1);
    checks++; if (n_re !== 80 || first_re !== 1 || last_re !== 80) begin errors++;
      $display("FAIL basic_re: count=%0d first=%0d last=%0d required 80/1/80", n_re, first_re, last_re); end
    checks++; if (ord_err !== 0) begin errors++;
      $display("FAIL basic_addr_order: bad=%0d required 0", ord_err); end
    checks++; if (n_dv !== 80 || first_dv !== 3 || last_dv !== 82) begin errors++;
      $display("FAIL basic_dv: count=%0d first=%0d last=%0d required 80/3/82", n_dv, first_dv, last_dv); end
    checks++; if (data_err !== 0) begin errors++;
      $display("FAIL basic_data: bad=%0d required 0", data_err); end
    checks++; if (n_last !== 1 || last_cyc !== 82 || stray_last !== 0) begin errors++;
      $display("FAIL basic_last: count=%0d cyc=%0d stray=%0d required 1/82/0", n_last, last_cyc, stray_last); end
    checks++; if (n_done !== 1 || done_cyc !== 83) begin errors++;
      $display("FAIL basic_done: count=%0d cyc=%0d required 1/83", n_done, done_cyc); end
    checks++; if (busy_first !== 1 || busy_last !== 82 || busy_n !== 82) begin errors++;
      $display("FAIL basic_busy: first=%0d last=%0d n=%0d required 1/82/82", busy_first, busy_last, busy_n); end
  endtask

  task automatic test_wrap;
    run_cmd(1'b0, 9'd500, 7'd1, 1000, 0, -1);
    checks++; if (n_re !== 40 || ord_err !== 0) begin errors++;
      $display("FAIL wrap_addr: count=%0d bad=%0d required 40/0", n_re, ord_err); end
    checks++; if (n_dv !== 40 || data_err !== 0) begin errors++;
      $display("FAIL wrap_data: count=%0d bad=%0d required 40/0", n_dv, data_err); end
    checks++; if (n_last !== 1 || last_cyc !== 42 || done_cyc !== 43) begin errors++;
      $display("FAIL wrap_last: n=%0d last=%0d done=%0d required 1/42/43", n_last, last_cyc, done_cyc); end
  endtask

  task automatic test_pause;
    run_cmd(1'b0, 9'd64, 7'd1, 11, 5, -1);
    checks++; if (n_re !== 40 || ord_err !== 0) begin errors++;
      $display("FAIL pause_re: count=%0d bad=%0d required 40/0", n_re, ord_err); end
    checks++; if (n_dv !== 40 || data_err !== 0) begin errors++;
      $display("FAIL pause_data: count=%0d bad=%0d required 40/0", n_dv, data_err); end
    checks++; if (dv10_cyc !== 12 || dv11_cyc !== 18) begin errors++;
      $display("FAIL pause_gap: word10=%0d word11=%0d required 12/18", dv10_cyc, dv11_cyc); end
    checks++; if (last_cyc !== 47 || done_cyc !== 48 || n_done !== 1) begin errors++;
      $display("FAIL pause_done: last=%0d done=%0d n=%0d required 47/48/1", last_cyc, done_cyc, n_done); end
  endtask

  task automatic test_zero_and_ignored;
    run_cmd(1'b0, 9'd5, 7'd0, 1000, 0, -1);
    checks++; if (done_cyc !== 1 || n_done !== 1 || n_re !== 0 || n_dv !== 0 || busy_n !== 0) begin errors++;
      $display("FAIL zero_blocks: done=%0d n_done=%0d re=%0d dv=%0d busy=%0d required 1/1/0/0/0",
               done_cyc, n_done, n_re, n_dv, busy_n); end
    run_cmd(1'b0, 9'd20, 7'd1, 1000, 0, 5);
    checks++; if (n_re !== 40 || ord_err !== 0 || data_err !== 0 || done_cyc !== 43) begin errors++;
      $display("FAIL restart_in_issue: re=%0d bad_addr=%0d bad_data=%0d done=%0d required 40/0/0/43",
               n_re, ord_err, data_err, done_cyc); end
    run_cmd(1'b0, 9'd20, 7'd1, 1000, 0, 43);
    checks++; if (n_re !== 40 || busy_n !== 42 || n_done !== 1) begin errors++;
      $display("FAIL restart_in_done: re=%0d busy=%0d n_done=%0d required 40/42/1", n_re, busy_n, n_done); end
  endtask

  task automatic test_reset_mid_op;
    int seen;
    int stray;
    seen = 0; stray = 0;
    @(negedge clk);
    sel_r = 1'b0; start = 1'b1; start_addr = 9'd100; num_blocks = 7'd1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int cyc = 1; cyc <= 60 && seen < 20; cyc++) begin
      #1;
      if (dv1) seen++;
      if (seen < 20) @(posedge clk);
    end
    checks++; if (seen !== 20) begin errors++;
      $display("FAIL reset_mid_reach: words=%0d required 20", seen); end
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({busy1, done1, re1, dv1, last1, addr1, dout1} !== 54'd0) begin errors++;
      $display("FAIL reset_mid_outputs: got %h required 0", {busy1, done1, re1, dv1, last1, addr1, dout1}); end
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    for (int cyc = 0; cyc < 10; cyc++) begin
      @(posedge clk);
      #2;
      if (dv1 || done1 || re1 || busy1 || last1) stray++;
    end
    checks++; if (stray !== 0) begin errors++;
      $display("FAIL reset_mid_quiet: active cycles=%0d required 0", stray); end
    run_cmd(1'b0, 9'd300, 7'd1, 1000, 0, -1);
    checks++; if (n_dv !== 40 || data_err !== 0 || ord_err !== 0 || done_cyc !== 43 || n_last !== 1) begin errors++;
      $display("FAIL reset_mid_rerun: dv=%0d bad_data=%0d bad_addr=%0d done=%0d last=%0d required 40/0/0/43/1",
               n_dv, data_err, ord_err, done_cyc, n_last); end
  endtask

  task automatic test_latency3;
    run_cmd(1'b1, 9'd7, 7'd1, 1000, 0, -1);
    checks++; if (first_re !== 1 || n_re !== 40 || ord_err !== 0) begin errors++;
      $display("FAIL lat3_re: first=%0d n=%0d bad=%0d required 1/40/0", first_re, n_re, ord_err); end
    checks++; if (first_dv !== 5 || last_dv !== 44 || n_dv !== 40 || data_err !== 0) begin errors++;
      $display("FAIL lat3_dv: first=%0d last=%0d n=%0d bad=%0d required 5/44/40/0", first_dv, last_dv, n_dv, data_err); end
    checks++; if (done_cyc !== 45 || last_cyc !== 44 || n_last !== 1) begin errors++;
      $display("FAIL lat3_done: done=%0d last=%0d n_last=%0d required 45/44/1", done_cyc, last_cyc, n_last); end
  endtask

  task automatic test_back_to_back;
    run_cmd(1'b0, 9'd200, 7'd1, 1000, 0, -1);
    run_cmd(1'b0, 9'd240, 7'd1, 1000, 0, -1);
    checks++; if (n_dv !== 40 || data_err !== 0 || done_cyc !== 43) begin errors++;
      $display("FAIL back_to_back: dv=%0d bad=%0d done=%0d required 40/0/43", n_dv, data_err, done_cyc); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wrap();
    test_pause();
    test_zero_and_ignored();
    test_reset_mid_op();
    test_latency3();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cram_read_streamer.md
Name: cram_read_streamer

Overview:
- Upstream neighbour of the CRAM-to-DRAM swizzle stage.
- On a start command it sequences reads from one CRAM port, in blocks of BLOCK_WORDS consecutive addresses.
- It absorbs the RAM read latency and emits a gap-free (except under pause) stream of data_valid / ram_data_out / ram_data_last, which feeds the swizzle's ping/pong buffers directly.
- Also provides a start/busy/done command handshake to the controlling sequencer.

Parameters:
DWIDTH, 40, CRAM port data width (equals swizzle RAM_PORT_DWIDTH)
AWIDTH, 9, CRAM port address width
RD_LATENCY, 1, cycles from ram_re to valid ram_rdata (1..4)
BLOCK_WORDS, 40, words per block (one swizzle buffer fill)
NBLK_WIDTH, 7, width of num_blocks

Ports:
clk  input  1  single clock, all logic on rising edge
reset  input  1  asynchronous active-high reset
start  input  1  command strobe, sampled only in IDLE
start_addr  input  AWIDTH  first CRAM address
num_blocks  input  NBLK_WIDTH  blocks to read (total words = num_blocks*BLOCK_WORDS)
pause  input  1  when high, no new read issued this cycle
busy  output  1  command in progress
done  output  1  one-cycle completion pulse
ram_addr  output  AWIDTH  CRAM read address
ram_re  output  1  CRAM read enable
ram_rdata  input  DWIDTH  CRAM read data, valid RD_LATENCY cycles after ram_re
data_valid  output  1  ram_data_out valid (to swizzle data_valid)
ram_data_out  output  DWIDTH  registered read data
ram_data_last  output  1  high with data_valid on final word of command

Behaviour:
- Reset (async, active-high): all outputs 0, state IDLE, latency tag pipe cleared. In-flight reads are discarded; no data_valid/done is produced for them after reset releases.
- State IDLE:
  - busy=0.
  - start=1 and num_blocks!=0 → latch start_addr, compute total = num_blocks*BLOCK_WORDS (width NBLK_WIDTH+6) → ISSUE; busy=1 next cycle.
  - start=1 and num_blocks==0 → DONE directly; no ram_re issued.
- State ISSUE:
  - Each cycle with pause=0: ram_re=1 and ram_addr=current address; then address+1 mod 2^AWIDTH (wraps 511→0); issued count+1.
  - pause=1: ram_re=0; address and count hold.
  - On issuing word total-1 → DRAIN.
- State DRAIN:
  - No reads issued; wait until the tag pipe is empty and the last word has been output → DONE.
- State DONE:
  - done=1 for exactly one cycle, busy=0 in the same cycle → IDLE.
- Tag pipe:
  - Depth RD_LATENCY carries {valid, last} alongside each issued read.
  - At pipe exit: ram_data_out <= ram_rdata, data_valid <= valid, ram_data_last <= last.
  - ram_data_out holds its value when data_valid=0.
- Latency:
  - start sampled at edge 0 → first ram_re at cycle 1 → first data_valid at cycle 2+RD_LATENCY.
  - done asserts the cycle after the data_valid carrying ram_data_last.
- Output ordering: words appear in address order; data_valid is never asserted without a preceding ram_re. ram_data_last is high exactly once per command and only with data_valid.
- start while busy (ISSUE/DRAIN/DONE): ignored; no latching, no error.
- pause is honoured in ISSUE only. It does not stall data already in the tag pipe, because the swizzle has no backpressure.
- Throughput: one word per cycle with pause=0; a command of N words with no pause spans N+RD_LATENCY+3 cycles from start to done.

Test Plan:
- Basic: RD_LATENCY=1, start_addr=0, num_blocks=2.
  - ram_re on cycles 1..80, addresses 0..79; data_valid on cycles 3..82 with ram_data_out = model[addr].
  - ram_data_last on cycle 82 only; done on cycle 83; busy high cycles 1..82.
- Wrap: start_addr=500, num_blocks=1 → addresses 500..511 then 0..27; 40 data_valid words, last on the 40th.
- Pause: num_blocks=1, pause high for 5 cycles after the 10th ram_re.
  - Exactly 40 ram_re and 40 data_valid, in address order; done delayed by 5 cycles vs no-pause.
  - data_valid gap of 5 cycles after word 10.
- Zero/ignored: num_blocks=0 → done pulse cycle 1, no ram_re, no data_valid. start reasserted mid-command with different start_addr → no effect on addresses or word count.
- Reset mid-op: assert reset asynchronously (not on an edge) during word 20 of a 40-word command.
  - All outputs 0 immediately; no data_valid/done after release.
  - A new command then runs correctly from IDLE.
- Latency sweep: RD_LATENCY=3, num_blocks=1 → first data_valid at cycle 5, last data_valid at cycle 44, done at cycle 45.
